ss_vdisk_arbiter: RTL

//  Parametrised N-channel virtual-disk request arbiter between the SCSI/CDROM image

---
 rtl/ss_vdisk_arbiter_pkg.sv | 46 ++++
 rtl/ss_vdisk_arbiter_if.sv | 34 +++
 rtl/ss_vdisk_arbiter_rr_pick.sv | 42 ++++
 rtl/ss_vdisk_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ss_vdisk_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ss_vdisk_pkg
//  Brief    : Shared types and helpers for the virtual-disk request arbiter:
//             FSM state encoding and a generic round-robin pick function.
//  Revision : 1.0  initial release
// ============================================================================
package ss_vdisk_pkg;

    // Largest channel count the round-robin helper supports.
    localparam int C_MAX_CH    = 8;
    localparam int C_MAX_IDX_W = 3;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        VD_IDLE  = 2'd0,
        VD_ISSUE = 2'd1,
        VD_XFER  = 2'd2,
        VD_DONE  = 2'd3
    } vd_state_t;

    // Round-robin search starting just after ptr, wrapping modulo nch.
    // Returns ptr unchanged when nothing is requesting; callers qualify the
    // result with |req.
    function automatic int unsigned rr_pick(
        input logic [C_MAX_CH-1:0] req,
        input int unsigned         ptr,
        input int unsigned         nch
    );
        int unsigned pick;
        int unsigned j;
        logic        found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= C_MAX_CH; k++) begin
            j = (ptr + k) % nch;
            if (!found && (k <= nch) && req[j[C_MAX_IDX_W-1:0]]) begin
                pick  = j;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ss_vdisk_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ss_vdisk_arbiter_if
//  Brief    : HPS sector-transfer port: request lines, LBA, ack and the
//             write-back data path. The arbiter is the master side.
//  Revision : 1.0  initial release
// ============================================================================
interface ss_vdisk_arbiter_if #(
    parameter int LBA_W = 32,
    parameter int DW    = 16
);
    logic [LBA_W-1:0] hps_lba;
    logic             hps_rd;
    logic             hps_wr;
    logic             hps_ack;
    logic [DW-1:0]    hps_buff_din;

    modport master (
        output hps_lba,
        output hps_rd,
        output hps_wr,
        output hps_buff_din,
        input  hps_ack
    );

    modport slave (
        input  hps_lba,
        input  hps_rd,
        input  hps_wr,
        input  hps_buff_din,
        output hps_ack
    );
endinterface
`default_nettype wire

// File: rtl/ss_vdisk_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : ss_rr_pick
//  Brief    : Combinational round-robin priority encoder. Picks the first
//             requester after ptr (wrapping), with a valid flag.
//  Revision : 1.0  initial release
// ============================================================================
module ss_rr_pick
    import ss_vdisk_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  wire  [NCH-1:0]   req,
    input  wire  [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [C_MAX_CH-1:0] w_req_ext;
    int unsigned         w_pick;

    // Zero-pad the request vector up to the helper's fixed width.
    generate
        for (genvar g = 0; g < C_MAX_CH; g++) begin : g_ext
            if (g < NCH) begin : g_live
                assign w_req_ext[g] = req[g];
            end else begin : g_pad
                assign w_req_ext[g] = 1'b0;
            end
        end
    endgenerate

    // Search from ptr+1 and report the winner.
    always_comb begin
        w_pick = rr_pick(w_req_ext, 32'(ptr), NCH);
        idx    = IDX_W'(w_pick);
        valid  = |req;
    end

endmodule
`default_nettype wire

// File: rtl/ss_vdisk_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ss_vdisk_arbiter
//  Brief    : N-channel virtual-disk request arbiter in front of the single
//             HPS sector-transfer port. Round-robin grant, mount tracking,
//             ack timeout and per-channel error pulses.
//  Revision : 1.0  initial release
// ============================================================================
module ss_vdisk_arbiter
    import ss_vdisk_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int LBA_W = 32,
    parameter int DW    = 16,
    parameter int TMO_W = 24
) (
    input  wire                  clk_sys,
    input  wire                  reset_n,
    input  wire  [NCH-1:0]       img_mounted,
    input  wire                  img_size_nz,
    input  wire  [NCH*LBA_W-1:0] ch_lba,
    input  wire  [NCH-1:0]       ch_rd,
    input  wire  [NCH-1:0]       ch_wr,
    output logic [NCH-1:0]       ch_ack,
    output logic [NCH-1:0]       ch_err,
    output logic [NCH-1:0]       ch_present,
    input  wire  [NCH*DW-1:0]    ch_buff_din,
    output logic                 busy,
    ss_vdisk_arbiter_if.master   hps
);

    localparam int C_IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    vd_state_t            r_state;
    vd_state_t            w_state_nxt;

    logic [C_IDX_W-1:0]   r_idx;
    logic [C_IDX_W-1:0]   r_rr;
    logic [LBA_W-1:0]     r_lba;
    logic                 r_dir_wr;
    logic                 r_hps_rd;
    logic                 r_hps_wr;
    logic [TMO_W-1:0]     r_cnt;
    logic [NCH-1:0]       r_err;
    logic [NCH-1:0]       r_present;

    logic [NCH-1:0]       w_pend;
    logic [C_IDX_W-1:0]   w_pick_idx;
    logic                 w_pick_valid;
    logic                 w_grant;
    logic                 w_reject;
    logic                 w_fault;
    logic                 w_eject;
    logic                 w_cnt_sat;
    logic [NCH-1:0]       w_ack;
    logic [DW-1:0]        w_buff;

    // A channel is pending while either of its request levels is high.
    assign w_pend = ch_rd | ch_wr;

    ss_rr_pick #(
        .NCH   (NCH),
        .IDX_W (C_IDX_W)
    ) u_pick (
        .req   (w_pend),
        .ptr   (r_rr),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= VD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the strobes that steer the datapath register.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_reject    = 1'b0;
        w_fault     = 1'b0;
        w_eject     = img_mounted[r_idx] & ~img_size_nz;
        w_cnt_sat   = &r_cnt;
        case (r_state)
            VD_IDLE: begin
                if (w_pick_valid) begin
                    if (!r_present[w_pick_idx]) begin
                        w_reject = 1'b1;
                    end else begin
                        w_grant     = 1'b1;
                        w_state_nxt = VD_ISSUE;
                    end
                end
            end
            VD_ISSUE: begin
                // Losing the image beats a simultaneous ack.
                if (w_eject) begin
                    w_fault     = 1'b1;
                    w_state_nxt = VD_DONE;
                end else if (hps.hps_ack) begin
                    w_state_nxt = VD_XFER;
                end else if (w_cnt_sat) begin
                    w_fault     = 1'b1;
                    w_state_nxt = VD_DONE;
                end
            end
            VD_XFER: begin
                if (w_eject) begin
                    w_fault     = 1'b1;
                    w_state_nxt = VD_DONE;
                end else if (!hps.hps_ack) begin
                    w_state_nxt = VD_DONE;
                end
            end
            VD_DONE: begin
                w_state_nxt = VD_IDLE;
            end
            default: begin
                w_state_nxt = VD_IDLE;
            end
        endcase
    end

    // Mount tracking, grant latches, timeout counter, error pulses and the
    // registered HPS request lines.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_idx     <= '0;
            r_rr      <= '0;
            r_lba     <= '0;
            r_dir_wr  <= 1'b0;
            r_hps_rd  <= 1'b0;
            r_hps_wr  <= 1'b0;
            r_cnt     <= '0;
            r_err     <= '0;
            r_present <= '0;
        end else begin
            r_err <= '0;
            for (int i = 0; i < NCH; i++) begin
                if (img_mounted[i]) begin
                    r_present[i] <= img_size_nz;
                end
            end
            // Unmounted requester: flag it and move the pointer past it so
            // other channels still get their turn.
            if (w_reject) begin
                r_err[w_pick_idx] <= 1'b1;
                r_rr              <= w_pick_idx;
            end
            if (w_grant) begin
                r_idx    <= w_pick_idx;
                r_lba    <= ch_lba[w_pick_idx*LBA_W +: LBA_W];
                r_dir_wr <= ch_wr[w_pick_idx] & ~ch_rd[w_pick_idx];
                if (ch_rd[w_pick_idx] & ch_wr[w_pick_idx]) begin
                    r_err[w_pick_idx] <= 1'b1;
                end
            end
            if (w_fault) begin
                r_err[r_idx] <= 1'b1;
            end
            if ((r_state == VD_ISSUE) && !w_cnt_sat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == VD_DONE) begin
                r_cnt <= '0;
                r_rr  <= r_idx;
            end
            // Request lines rise one cycle into ISSUE and drop on the edge
            // that leaves it (ack, timeout or eject).
            r_hps_rd <= (r_state == VD_ISSUE) && (w_state_nxt == VD_ISSUE) && !r_dir_wr;
            r_hps_wr <= (r_state == VD_ISSUE) && (w_state_nxt == VD_ISSUE) &&  r_dir_wr;
        end
    end

    // Ack mirror and write-back mux are live only during the data phase.
    always_comb begin
        w_ack  = '0;
        w_buff = '0;
        if (r_state == VD_XFER) begin
            for (int i = 0; i < NCH; i++) begin
                w_ack[i] = hps.hps_ack && (r_idx == C_IDX_W'(i));
            end
            w_buff = ch_buff_din[r_idx*DW +: DW];
        end
    end

    assign ch_ack           = w_ack;
    assign ch_err           = r_err;
    assign ch_present       = r_present;
    assign busy             = (r_state != VD_IDLE);
    assign hps.hps_lba      = r_lba;
    assign hps.hps_rd       = r_hps_rd;
    assign hps.hps_wr       = r_hps_wr;
    assign hps.hps_buff_din = w_buff;

endmodule
`default_nettype wire
